// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one RAM command port between instruction fetch
// and the load/store unit. Data has priority, with a starvation guard for fetch and an abort timeout.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_cack,
    output logic              o_f_ready,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [15:0]       i_d_wdata,
    output logic              o_d_cack,
    output logic              o_d_ready,
    output logic [31:0]       o_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic              i_mem_valid,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            r_state,     w_stateNext;
    logic              r_ownerData, w_ownerDataNext;
    logic [SW-1:0]     r_streak,    w_streakNext;
    logic [TW-1:0]     r_toutCnt,   w_toutCntNext;
    logic              r_fCack,     w_fCackNext;
    logic              r_fReady,    w_fReadyNext;
    logic              r_dCack,     w_dCackNext;
    logic              r_dReady,    w_dReadyNext;
    logic [31:0]       r_rdata,     w_rdataNext;
    logic              r_memReq,    w_memReqNext;
    logic              r_memWe,     w_memWeNext;
    logic [ADDR_W-1:0] r_memAddr,   w_memAddrNext;
    logic [15:0]       r_memWdata,  w_memWdataNext;
    logic              r_toutErr,   w_toutErrNext;

    logic w_grantData;
    logic w_grantFetch;
    logic w_memDone;

    // Fetch wins only once data has taken STARVE_LIMIT grants in a row past it.
    assign w_grantData  = i_d_req && !(i_f_req && (r_streak == STREAK_MAX));
    assign w_grantFetch = i_f_req && !w_grantData;
    assign w_memDone    = (r_state == ISSUE) ? (i_mem_ack && i_mem_valid) : i_mem_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ownerData <= 1'b0;
            r_streak    <= '0;
            r_toutCnt   <= '0;
            r_fCack     <= 1'b0;
            r_fReady    <= 1'b0;
            r_dCack     <= 1'b0;
            r_dReady    <= 1'b0;
            r_rdata     <= '0;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_toutErr   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_ownerData <= w_ownerDataNext;
            r_streak    <= w_streakNext;
            r_toutCnt   <= w_toutCntNext;
            r_fCack     <= w_fCackNext;
            r_fReady    <= w_fReadyNext;
            r_dCack     <= w_dCackNext;
            r_dReady    <= w_dReadyNext;
            r_rdata     <= w_rdataNext;
            r_memReq    <= w_memReqNext;
            r_memWe     <= w_memWeNext;
            r_memAddr   <= w_memAddrNext;
            r_memWdata  <= w_memWdataNext;
            r_toutErr   <= w_toutErrNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_ownerDataNext = r_ownerData;
        w_streakNext    = r_streak;
        w_toutCntNext   = r_toutCnt;
        w_fCackNext     = 1'b0;
        w_fReadyNext    = 1'b0;
        w_dCackNext     = 1'b0;
        w_dReadyNext    = 1'b0;
        w_rdataNext     = r_rdata;
        w_memReqNext    = r_memReq;
        w_memWeNext     = r_memWe;
        w_memAddrNext   = r_memAddr;
        w_memWdataNext  = r_memWdata;
        w_toutErrNext   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grantData) begin
                    w_memAddrNext   = i_d_addr;
                    w_memWeNext     = i_d_we;
                    w_memWdataNext  = i_d_wdata;
                    w_memReqNext    = 1'b1;
                    w_dCackNext     = 1'b1;
                    w_ownerDataNext = 1'b1;
                    w_toutCntNext   = '0;
                    w_stateNext     = ISSUE;
                    if (!i_f_req) begin
                        w_streakNext = '0;
                    end else if (r_streak != STREAK_MAX) begin
                        w_streakNext = r_streak + 1'b1;
                    end
                end else if (w_grantFetch) begin
                    w_memAddrNext   = i_f_addr;
                    w_memWeNext     = 1'b0;
                    w_memReqNext    = 1'b1;
                    w_fCackNext     = 1'b1;
                    w_ownerDataNext = 1'b0;
                    w_toutCntNext   = '0;
                    w_streakNext    = '0;
                    w_stateNext     = ISSUE;
                end
            end

            // A real completion on the final cycle beats the timeout abort.
            ISSUE, WAIT: begin
                w_toutCntNext = r_toutCnt + 1'b1;
                if (w_memDone) begin
                    w_memReqNext = 1'b0;
                    w_fReadyNext = !r_ownerData;
                    w_dReadyNext = r_ownerData;
                    if (!r_memWe) begin
                        w_rdataNext = i_mem_rdata;
                    end
                    w_stateNext = IDLE;
                end else if (r_toutCnt == TOUT_LAST) begin
                    w_memReqNext  = 1'b0;
                    w_toutErrNext = 1'b1;
                    w_fReadyNext  = !r_ownerData;
                    w_dReadyNext  = r_ownerData;
                    w_rdataNext   = '0;
                    w_stateNext   = IDLE;
                end else if ((r_state == ISSUE) && i_mem_ack) begin
                    w_memReqNext = 1'b0;
                    w_stateNext  = WAIT;
                end
            end

            default: begin
                w_stateNext  = IDLE;
                w_memReqNext = 1'b0;
            end
        endcase
    end

    assign o_f_cack      = r_fCack;
    assign o_f_ready     = r_fReady;
    assign o_d_cack      = r_dCack;
    assign o_d_ready     = r_dReady;
    assign o_rdata       = r_rdata;
    assign o_mem_req     = r_memReq;
    assign o_mem_we      = r_memWe;
    assign o_mem_addr    = r_memAddr;
    assign o_mem_wdata   = r_memWdata;
    assign o_timeout_err = r_toutErr;
    assign o_busy        = (r_state != IDLE);

endmodule
